uart_tx_fifo: RTL
=================

# uart_tx_fifo

UART 8N1 transmitter with a small input FIFO, bit timing matched to the 16x-oversampled receiver in this design (CLKS_PER_BIT clocks per bit). It accepts bytes from on-chip logic over a valid/ready handshake, buffers them, and serialises them LSB-first onto `tx` with no idle gap between queued frames. It sits upstream of the receiver on the serial line and is used for host links and for RX loopback testing.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clocks per serial bit; must be at least 2.
- `FIFO_DEPTH`, default 4: FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_data` is offered this cycle.
- `in_data`  in  8  byte to transmit.
- `in_ready`  out  1  FIFO can accept a byte; combinational `!full`.
- `tx`  out  1  serial line, registered, idles high.
- `busy`  out  1  registered; high while the FSM is not in IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of queued bytes, not counting the byte currently being shifted.

## Operation
- Push: on a rising edge with `in_valid && in_ready`, `in_data` is written at `wr_ptr`. When full, no push occurs, even if a pop happens in the same cycle.
- Pop: the FSM pops the FIFO head into the 8-bit shift register whenever it enters START. A push and a pop in the same cycle leave `fifo_count` unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
- `full` = (`fifo_count` == FIFO_DEPTH). `empty` = (`fifo_count` == 0).
- The bit counter `cnt` counts from 0 to CLKS_PER_BIT-1. A bit ends when `cnt` == CLKS_PER_BIT-1; `cnt` then returns to 0. The data-bit index `bit_i` is 3 bits wide.
- FSM states:
  - IDLE: `tx`=1. If not empty, pop the head and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with `bit_i`=0.
  - DATA: `tx`=shreg[0]. At the end of each bit, shift right and increment `bit_i`. At the end of the bit with `bit_i`==7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end of the bit, if not empty, pop and go directly to START; otherwise go to IDLE.
- `tx` is driven from a register updated with the next state, so the line level changes exactly at state boundaries.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `in_ready`=1, state IDLE, pointers and counters 0. Reset flushes FIFO contents.
- Reset mid-frame: `tx` returns to 1 on the reset edge. The partial frame and all queued bytes are discarded. There is no partial-frame completion.
- Latency into an idle, empty block:
  - Push at edge N.
  - Pop at edge N+1; from that edge `tx`=0 and `busy`=1.
  - The start bit spans edges N+1 to N+1+CLKS_PER_BIT.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit, with zero idle cycles.
- `busy` falls on the edge that ends the last stop bit when the FIFO is empty.
- `in_ready` reasserts in the cycle after the pop that clears `full`.
- `in_data` is sampled only on the push edge and need not be held afterwards.

## Test plan
- Reset, then hold `in_valid`=0 for 100 cycles -> `tx`=1, `busy`=0, `fifo_count`=0, `in_ready`=1 throughout.
- Push 0xA5 (CLKS_PER_BIT=16):
  - `tx` is 0 for 16 cycles starting one edge after the push.
  - Then 1,0,1,0,0,1,0,1, each for 16 cycles.
  - Then 1 for 16 cycles.
  - `busy` falls 160 cycles after the start bit began.
  - Looped into the receiver, the receiver `data` becomes 0xA5.
- Hold `in_valid`=1 with bytes 0x01..0x06 (FIFO_DEPTH=4):
  - Bytes 0x01..0x05 are accepted on 5 consecutive edges, with 0x01 popped on edge 2.
  - `fifo_count` reaches 4 and `in_ready` falls.
  - 0x06 is accepted only after 0x02 is popped, 160 cycles after frame 0x01 began.
  - All six frames are contiguous, with no idle gaps.
- Reset asserted during DATA bit 3 of 0x3C, with two more bytes queued -> `tx`=1 from the reset edge, `fifo_count`=0, no further frames.
- Push 0x00 then 0xFF:
  - Frame 0x00 shows `tx` low for 144 cycles, then a 16-cycle stop bit.
  - Frame 0xFF shows a 16-cycle start bit, then `tx` high for 144 cycles.
  - Checks stop-bit placement and back-to-back transition.
- Push 9 bytes, waiting for `in_ready` each time (FIFO_DEPTH=4) -> wr/rd pointers wrap twice, and the bytes are transmitted in push order with no loss or duplication.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   8N1 UART transmitter fed by a small byte FIFO. Bytes arrive over a
//   valid/ready handshake and are sent LSB-first on tx. Queued frames
//   follow each other with no idle gap between them.
//
//   Parameters:
//     CLKS_PER_BIT  clocks per serial bit (>= 2)
//     FIFO_DEPTH    FIFO entries (power of two, >= 2)
//   Ports:
//     clk         clock
//     reset       synchronous, active-high reset; flushes FIFO and frame
//     in_valid    in_data offered this cycle
//     in_data     byte to transmit
//     in_ready    FIFO not full (combinational)
//     tx          registered serial line, idles high
//     busy        registered, high while a frame is being sent
//     fifo_count  queued bytes, excluding the byte being shifted out
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_n;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2:0]      bit_i, bit_i_n;
   logic [7:0]      shreg, shreg_n;
   logic            tx_n;
   logic            full, empty, push, pop, bit_end;

   assign full       = (count == CNT_FULL);
   assign empty      = (count == '0);
   assign in_ready   = !full;
   assign push       = in_valid && !full;
   assign bit_end    = (cnt == CNT_LAST);
   assign fifo_count = count;

   always_comb begin
      state_n = state;
      cnt_n   = bit_end ? '0 : cnt + CW'(1);
      bit_i_n = bit_i;
      shreg_n = shreg;
      pop     = 1'b0;
      tx_n    = 1'b1;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!empty) begin
               pop     = 1'b1;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               bit_i_n = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_n = {1'b0, shreg[7:1]};
               bit_i_n = bit_i + 3'd1;
               if (bit_i == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (pop) shreg_n = mem[rd_ptr];
      // Line level follows the state being entered, so tx changes exactly
      // on state boundaries with no extra register stage.
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shreg_n[0];
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         bit_i  <= '0;
         shreg  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         tx     <= 1'b1;
         busy   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         bit_i <= bit_i_n;
         shreg <= shreg_n;
         tx    <= tx_n;
         busy  <= (state_n != IDLE);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: count and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule
